// File: rtl/pf_mem_request_handler.sv
// Prefetch request handler: filters prefetches, tracks them in an MSHR table, issues BUS_LOADs, returns fills.
// Optional PF_DUP_FILTER_EN drops requests whose aligned address is already tracked by a live entry.
module pf_mem_request_handler #(
  parameter int NUM_MSHR = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        pf_request_valid,
  input  logic [63:0] pf_requested_addr,
  input  logic        pf_addr_in_cache,
  input  logic        br_pred_wrong,
  input  logic        icache_demand_busy,
  output logic        icache_pf_stall,
  output logic [1:0]  pf2mem_command,
  output logic [63:0] pf2mem_addr,
  input  logic [3:0]  mem2pf_response,
  input  logic [3:0]  mem2pf_tag,
  input  logic [63:0] mem2pf_data,
  output logic        pf_fill_valid,
  output logic [63:0] pf_fill_addr,
  output logic [63:0] pf_fill_data
);
  localparam int IW = (NUM_MSHR > 1) ? $clog2(NUM_MSHR) : 1;

  typedef enum logic [1:0] {
    FREE       = 2'd0,
    WAIT_ISSUE = 2'd1,
    WAIT_DATA  = 2'd2
  } entry_state_t;

  entry_state_t state_reg [NUM_MSHR];
  entry_state_t state_next[NUM_MSHR];
  logic [63:3]  addr_reg  [NUM_MSHR];
  logic [63:3]  addr_next [NUM_MSHR];
  logic [3:0]   tag_reg   [NUM_MSHR];
  logic [3:0]   tag_next  [NUM_MSHR];

  logic          free_found, issue_found, ret_hit, dup_hit;
  logic [IW-1:0] free_idx, issue_idx, ret_idx;
  logic          issue_go, issue_ok, accept, alloc;
  logic          unused_offset;

  assign unused_offset = ^pf_requested_addr[2:0];

  // Scan downwards so the lowest matching index wins
  always_comb begin
    free_found  = 1'b0;
    free_idx    = '0;
    issue_found = 1'b0;
    issue_idx   = '0;
    ret_hit     = 1'b0;
    ret_idx     = '0;
    dup_hit     = 1'b0;
    for (int i = NUM_MSHR - 1; i >= 0; i--) begin
      if (state_reg[i] == FREE) begin
        free_found = 1'b1;
        free_idx   = IW'(i);
      end
      if (state_reg[i] == WAIT_ISSUE) begin
        issue_found = 1'b1;
        issue_idx   = IW'(i);
      end
      if (state_reg[i] == WAIT_DATA && mem2pf_tag != 4'd0 && tag_reg[i] == mem2pf_tag) begin
        ret_hit = 1'b1;
        ret_idx = IW'(i);
      end
`ifdef PF_DUP_FILTER_EN
      if (state_reg[i] != FREE && addr_reg[i] == pf_requested_addr[63:3])
        dup_hit = 1'b1;
`endif
    end
  end

  assign icache_pf_stall = !free_found;
  assign issue_go        = issue_found && !icache_demand_busy;
  assign issue_ok        = issue_go && (mem2pf_response != 4'd0);
  assign pf2mem_command  = issue_go ? 2'd1 : 2'd0;
  assign pf2mem_addr     = issue_go ? {addr_reg[issue_idx], 3'b000} : 64'd0;
  assign accept          = pf_request_valid && free_found && !br_pred_wrong;
  assign alloc           = accept && !pf_addr_in_cache && !dup_hit;

  // A memory-accepted issue wins over a flush: that transaction is already real
  always_comb begin
    for (int i = 0; i < NUM_MSHR; i++) begin
      state_next[i] = state_reg[i];
      addr_next[i]  = addr_reg[i];
      tag_next[i]   = tag_reg[i];
      case (state_reg[i])
        FREE: begin
          if (alloc && free_idx == IW'(i)) begin
            state_next[i] = WAIT_ISSUE;
            addr_next[i]  = pf_requested_addr[63:3];
          end
        end
        WAIT_ISSUE: begin
          if (issue_ok && issue_idx == IW'(i)) begin
            state_next[i] = WAIT_DATA;
            tag_next[i]   = mem2pf_response;
          end else if (br_pred_wrong) begin
            state_next[i] = FREE;
          end
        end
        WAIT_DATA: begin
          if (ret_hit && ret_idx == IW'(i))
            state_next[i] = FREE;
        end
        default: state_next[i] = FREE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_MSHR; i++) begin
        state_reg[i] <= FREE;
        addr_reg[i]  <= '0;
        tag_reg[i]   <= '0;
      end
      pf_fill_valid <= 1'b0;
      pf_fill_addr  <= '0;
      pf_fill_data  <= '0;
    end else begin
      for (int i = 0; i < NUM_MSHR; i++) begin
        state_reg[i] <= state_next[i];
        addr_reg[i]  <= addr_next[i];
        tag_reg[i]   <= tag_next[i];
      end
      pf_fill_valid <= ret_hit;
      if (ret_hit) begin
        pf_fill_addr <= {addr_reg[ret_idx], 3'b000};
        pf_fill_data <= mem2pf_data;
      end
    end
  end
endmodule

// File: tb/tb_pf_mem_request_handler.sv
// Directed bench for pf_mem_request_handler; expectations follow PF_DUP_FILTER_EN when defined.
module tb_pf_mem_request_handler;
  logic        clk = 1'b0;
  logic        reset;
  logic        pf_request_valid;
  logic [63:0] pf_requested_addr;
  logic        pf_addr_in_cache;
  logic        br_pred_wrong;
  logic        icache_demand_busy;
  logic        icache_pf_stall;
  logic [1:0]  pf2mem_command;
  logic [63:0] pf2mem_addr;
  logic [3:0]  mem2pf_response;
  logic [3:0]  mem2pf_tag;
  logic [63:0] mem2pf_data;
  logic        pf_fill_valid;
  logic [63:0] pf_fill_addr;
  logic [63:0] pf_fill_data;

  int pass_cnt  = 0;
  int total_cnt = 0;

  pf_mem_request_handler #(.NUM_MSHR(4)) dut (
    .clk(clk), .reset(reset),
    .pf_request_valid(pf_request_valid), .pf_requested_addr(pf_requested_addr),
    .pf_addr_in_cache(pf_addr_in_cache), .br_pred_wrong(br_pred_wrong),
    .icache_demand_busy(icache_demand_busy), .icache_pf_stall(icache_pf_stall),
    .pf2mem_command(pf2mem_command), .pf2mem_addr(pf2mem_addr),
    .mem2pf_response(mem2pf_response), .mem2pf_tag(mem2pf_tag), .mem2pf_data(mem2pf_data),
    .pf_fill_valid(pf_fill_valid), .pf_fill_addr(pf_fill_addr), .pf_fill_data(pf_fill_data)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "timeout");
  end

  // Advance to just after the next rising edge and clear single-cycle stimulus
  task automatic next_slot();
    @(posedge clk);
    #1;
    pf_request_valid = 1'b0;
    pf_addr_in_cache = 1'b0;
    br_pred_wrong    = 1'b0;
    mem2pf_response  = 4'd0;
    mem2pf_tag       = 4'd0;
    mem2pf_data      = 64'd0;
  endtask

  task automatic test_reset();
    reset = 1'b0; pf_request_valid = 0; pf_requested_addr = 0; pf_addr_in_cache = 0;
    br_pred_wrong = 0; icache_demand_busy = 0; mem2pf_response = 0; mem2pf_tag = 0; mem2pf_data = 0;
    repeat (2) @(posedge clk);
    #1;
    total_cnt++; if (icache_pf_stall !== 1'b0) $display("FAIL rst_stall: got %0b expected 0", icache_pf_stall); else pass_cnt++;
    total_cnt++; if (pf2mem_command !== 2'd0) $display("FAIL rst_cmd: got %0d expected 0", pf2mem_command); else pass_cnt++;
    total_cnt++; if (pf2mem_addr !== 64'd0) $display("FAIL rst_addr: got %0h expected 0", pf2mem_addr); else pass_cnt++;
    total_cnt++; if (pf_fill_valid !== 1'b0) $display("FAIL rst_fill_valid: got %0b expected 0", pf_fill_valid); else pass_cnt++;
    total_cnt++; if (pf_fill_addr !== 64'd0 || pf_fill_data !== 64'd0) $display("FAIL rst_fill_bus: got %0h/%0h expected 0/0", pf_fill_addr, pf_fill_data); else pass_cnt++;
    reset = 1'b1;
  endtask

  task automatic test_basic();
    next_slot(); pf_request_valid = 1; pf_requested_addr = 64'h105; #1;
    total_cnt++; if (pf2mem_command !== 2'd0) $display("FAIL basic_no_early_issue: got %0d expected 0", pf2mem_command); else pass_cnt++;
    next_slot(); #1;
    total_cnt++; if (pf2mem_command !== 2'd1) $display("FAIL basic_cmd: got %0d expected 1", pf2mem_command); else pass_cnt++;
    total_cnt++; if (pf2mem_addr !== 64'h100) $display("FAIL basic_addr: got %0h expected 100", pf2mem_addr); else pass_cnt++;
    mem2pf_response = 4'd2;
    next_slot(); mem2pf_tag = 4'd2; mem2pf_data = 64'hAB; #1;
    total_cnt++; if (pf2mem_command !== 2'd0) $display("FAIL basic_cmd_after_accept: got %0d expected 0", pf2mem_command); else pass_cnt++;
    next_slot(); #1;
    total_cnt++; if (pf_fill_valid !== 1'b1) $display("FAIL basic_fill_valid: got %0b expected 1", pf_fill_valid); else pass_cnt++;
    total_cnt++; if (pf_fill_addr !== 64'h100) $display("FAIL basic_fill_addr: got %0h expected 100", pf_fill_addr); else pass_cnt++;
    total_cnt++; if (pf_fill_data !== 64'hAB) $display("FAIL basic_fill_data: got %0h expected ab", pf_fill_data); else pass_cnt++;
    next_slot(); #1;
    total_cnt++; if (pf_fill_valid !== 1'b0) $display("FAIL basic_fill_pulse: got %0b expected 0", pf_fill_valid); else pass_cnt++;
  endtask

  task automatic test_in_cache();
    next_slot(); pf_request_valid = 1; pf_requested_addr = 64'hA00; pf_addr_in_cache = 1; #1;
    next_slot(); #1;
    total_cnt++; if (pf2mem_command !== 2'd0) $display("FAIL in_cache_drop: got %0d expected 0", pf2mem_command); else pass_cnt++;
  endtask

  task automatic test_stall();
    for (int k = 0; k < 4; k++) begin
      next_slot(); pf_request_valid = 1; pf_requested_addr = 64'(k * 8); #1;
      total_cnt++; if (icache_pf_stall !== 1'b0) $display("FAIL stall_fill_%0d: got %0b expected 0", k, icache_pf_stall); else pass_cnt++;
    end
    next_slot(); pf_request_valid = 1; pf_requested_addr = 64'h20; #1;
    total_cnt++; if (icache_pf_stall !== 1'b1) $display("FAIL stall_full: got %0b expected 1", icache_pf_stall); else pass_cnt++;
    total_cnt++; if (pf2mem_command !== 2'd1 || pf2mem_addr !== 64'h0) $display("FAIL stall_reissue: got %0d/%0h expected 1/0", pf2mem_command, pf2mem_addr); else pass_cnt++;
    next_slot(); pf_request_valid = 1; pf_requested_addr = 64'h20; #1;
    total_cnt++; if (icache_pf_stall !== 1'b1) $display("FAIL stall_held: got %0b expected 1", icache_pf_stall); else pass_cnt++;
    br_pred_wrong = 1;
    next_slot(); #1;
    total_cnt++; if (icache_pf_stall !== 1'b0) $display("FAIL stall_flush_free: got %0b expected 0", icache_pf_stall); else pass_cnt++;
    total_cnt++; if (pf2mem_command !== 2'd0) $display("FAIL stall_flush_cmd: got %0d expected 0", pf2mem_command); else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    next_slot(); pf_request_valid = 1; pf_requested_addr = 64'h200; #1;
    next_slot(); #1;
    total_cnt++; if (pf2mem_addr !== 64'h200) $display("FAIL rmid_addr0: got %0h expected 200", pf2mem_addr); else pass_cnt++;
    mem2pf_response = 4'd3;
    next_slot(); pf_request_valid = 1; pf_requested_addr = 64'h208; #1;
    next_slot(); #1;
    total_cnt++; if (pf2mem_command !== 2'd1 || pf2mem_addr !== 64'h208) $display("FAIL rmid_addr1: got %0d/%0h expected 1/208", pf2mem_command, pf2mem_addr); else pass_cnt++;
    reset = 1'b0; #1;
    total_cnt++; if (pf2mem_command !== 2'd0 || pf2mem_addr !== 64'd0) $display("FAIL rmid_cmd_async: got %0d/%0h expected 0/0", pf2mem_command, pf2mem_addr); else pass_cnt++;
    total_cnt++; if (icache_pf_stall !== 1'b0 || pf_fill_valid !== 1'b0) $display("FAIL rmid_stall_fill: got %0b/%0b expected 0/0", icache_pf_stall, pf_fill_valid); else pass_cnt++;
    #1 reset = 1'b1;
    next_slot(); mem2pf_tag = 4'd3; mem2pf_data = 64'h33; #1;
    next_slot(); #1;
    total_cnt++; if (pf_fill_valid !== 1'b0) $display("FAIL rmid_stale_tag: got %0b expected 0", pf_fill_valid); else pass_cnt++;
  endtask

  task automatic test_demand_busy();
    next_slot(); icache_demand_busy = 1; pf_request_valid = 1; pf_requested_addr = 64'h300; #1;
    for (int k = 0; k < 5; k++) begin
      next_slot(); #1;
      total_cnt++; if (pf2mem_command !== 2'd0 || pf2mem_addr !== 64'd0) $display("FAIL busy_hold_%0d: got %0d/%0h expected 0/0", k, pf2mem_command, pf2mem_addr); else pass_cnt++;
    end
    next_slot(); icache_demand_busy = 0; #1;
    total_cnt++; if (pf2mem_command !== 2'd1 || pf2mem_addr !== 64'h300) $display("FAIL busy_release: got %0d/%0h expected 1/300", pf2mem_command, pf2mem_addr); else pass_cnt++;
    mem2pf_response = 4'd5;
    next_slot(); mem2pf_tag = 4'd5; mem2pf_data = 64'h55; #1;
    next_slot(); #1;
    total_cnt++; if (pf_fill_valid !== 1'b1 || pf_fill_addr !== 64'h300 || pf_fill_data !== 64'h55) $display("FAIL busy_fill: got %0b/%0h/%0h expected 1/300/55", pf_fill_valid, pf_fill_addr, pf_fill_data); else pass_cnt++;
  endtask

  task automatic test_dup();
    next_slot(); pf_request_valid = 1; pf_requested_addr = 64'h40; #1;
    next_slot(); #1;
    total_cnt++; if (pf2mem_addr !== 64'h40) $display("FAIL dup_first_addr: got %0h expected 40", pf2mem_addr); else pass_cnt++;
    mem2pf_response = 4'd6;
    next_slot(); pf_request_valid = 1; pf_requested_addr = 64'h40; #1;
    next_slot(); #1;
`ifdef PF_DUP_FILTER_EN
    total_cnt++; if (pf2mem_command !== 2'd0) $display("FAIL dup_filtered: got %0d expected 0", pf2mem_command); else pass_cnt++;
`else
    total_cnt++; if (pf2mem_command !== 2'd1 || pf2mem_addr !== 64'h40) $display("FAIL dup_second_load: got %0d/%0h expected 1/40", pf2mem_command, pf2mem_addr); else pass_cnt++;
    mem2pf_response = 4'd7;
`endif
    next_slot(); mem2pf_tag = 4'd6; mem2pf_data = 64'h61; #1;
    next_slot();
`ifndef PF_DUP_FILTER_EN
    mem2pf_tag = 4'd7; mem2pf_data = 64'h72;
`endif
    #1;
    total_cnt++; if (pf_fill_valid !== 1'b1 || pf_fill_addr !== 64'h40 || pf_fill_data !== 64'h61) $display("FAIL dup_fill1: got %0b/%0h/%0h expected 1/40/61", pf_fill_valid, pf_fill_addr, pf_fill_data); else pass_cnt++;
    next_slot(); #1;
`ifdef PF_DUP_FILTER_EN
    total_cnt++; if (pf_fill_valid !== 1'b0) $display("FAIL dup_single_fill: got %0b expected 0", pf_fill_valid); else pass_cnt++;
`else
    total_cnt++; if (pf_fill_valid !== 1'b1 || pf_fill_data !== 64'h72) $display("FAIL dup_fill2: got %0b/%0h expected 1/72", pf_fill_valid, pf_fill_data); else pass_cnt++;
`endif
    next_slot(); #1;
    total_cnt++; if (pf_fill_valid !== 1'b0 || pf2mem_command !== 2'd0) $display("FAIL dup_idle: got %0b/%0d expected 0/0", pf_fill_valid, pf2mem_command); else pass_cnt++;
  endtask

  task automatic test_flush();
    next_slot(); pf_request_valid = 1; pf_requested_addr = 64'h500; #1;
    next_slot(); #1;
    total_cnt++; if (pf2mem_addr !== 64'h500) $display("FAIL flush_issue_addr: got %0h expected 500", pf2mem_addr); else pass_cnt++;
    mem2pf_response = 4'd8;
    next_slot(); icache_demand_busy = 1; pf_request_valid = 1; pf_requested_addr = 64'h600; #1;
    next_slot(); pf_request_valid = 1; pf_requested_addr = 64'h700; #1;
    next_slot(); br_pred_wrong = 1; pf_request_valid = 1; pf_requested_addr = 64'h800; #1;
    next_slot(); icache_demand_busy = 0; #1;
    total_cnt++; if (pf2mem_command !== 2'd0) $display("FAIL flush_cleared: got %0d expected 0", pf2mem_command); else pass_cnt++;
    total_cnt++; if (icache_pf_stall !== 1'b0) $display("FAIL flush_stall: got %0b expected 0", icache_pf_stall); else pass_cnt++;
    mem2pf_tag = 4'd8; mem2pf_data = 64'h88;
    next_slot(); #1;
    total_cnt++; if (pf_fill_valid !== 1'b1 || pf_fill_addr !== 64'h500 || pf_fill_data !== 64'h88) $display("FAIL flush_fill: got %0b/%0h/%0h expected 1/500/88", pf_fill_valid, pf_fill_addr, pf_fill_data); else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    next_slot(); pf_request_valid = 1; pf_requested_addr = 64'h900; #1;
    next_slot(); #1;
    total_cnt++; if (pf2mem_addr !== 64'h900) $display("FAIL b2b_addr0: got %0h expected 900", pf2mem_addr); else pass_cnt++;
    mem2pf_response = 4'd9; pf_request_valid = 1; pf_requested_addr = 64'h908;
    next_slot(); #1;
    total_cnt++; if (pf2mem_command !== 2'd1 || pf2mem_addr !== 64'h908) $display("FAIL b2b_addr1: got %0d/%0h expected 1/908", pf2mem_command, pf2mem_addr); else pass_cnt++;
    mem2pf_response = 4'd10; mem2pf_tag = 4'd9; mem2pf_data = 64'h99;
    next_slot(); mem2pf_tag = 4'd10; mem2pf_data = 64'hAA; #1;
    total_cnt++; if (pf_fill_valid !== 1'b1 || pf_fill_addr !== 64'h900 || pf_fill_data !== 64'h99) $display("FAIL b2b_fill0: got %0b/%0h/%0h expected 1/900/99", pf_fill_valid, pf_fill_addr, pf_fill_data); else pass_cnt++;
    next_slot(); #1;
    total_cnt++; if (pf_fill_valid !== 1'b1 || pf_fill_addr !== 64'h908 || pf_fill_data !== 64'hAA) $display("FAIL b2b_fill1: got %0b/%0h/%0h expected 1/908/aa", pf_fill_valid, pf_fill_addr, pf_fill_data); else pass_cnt++;
    next_slot(); #1;
    total_cnt++; if (pf_fill_valid !== 1'b0) $display("FAIL b2b_pulse: got %0b expected 0", pf_fill_valid); else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_in_cache();
    test_stall();
    test_reset_mid();
    test_demand_busy();
    test_dup();
    test_flush();
    test_back_to_back();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
